// File: rtl/ext_int_ctrl_pkg.sv
// Shared constants for the external interrupt controller: register map,
// FSM encoding and the fixed-priority pick.
package ext_int_pkg;

  localparam int ID_W = 3;

  localparam logic [1:0] ADDR_ENABLE = 2'd0;
  localparam logic [1:0] ADDR_MODE   = 2'd1;
  localparam logic [1:0] ADDR_POL    = 2'd2;
  localparam logic [1:0] ADDR_PEND   = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_e;

  // Lowest set index wins, so EINT0 has the highest priority.
  function automatic logic [ID_W-1:0] first_set(input logic [7:0] req);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) r = ID_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ext_int_ctrl_if.sv
// Pin, configuration and CPU handshake signals of the external interrupt
// controller. The master side is the CPU plus pin mux, the slave is the controller.
interface ext_int_ctrl_if #(
  parameter int NUM_SRC = 2
) ();
  import ext_int_pkg::*;

  logic [NUM_SRC-1:0] eint_in;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [7:0]         cfg_wdata;
  logic [7:0]         cfg_rdata;
  logic               irq;
  logic [ID_W-1:0]    irq_id;
  logic               irq_ack;
  logic               irq_done;

  modport master (
    output eint_in, cfg_we, cfg_addr, cfg_wdata, irq_ack, irq_done,
    input  cfg_rdata, irq, irq_id
  );

  modport slave (
    input  eint_in, cfg_we, cfg_addr, cfg_wdata, irq_ack, irq_done,
    output cfg_rdata, irq, irq_id
  );

endinterface

// File: rtl/ext_int_ctrl_sync_edge.sv
// One interrupt line: multi-flop synchronizer, one-cycle history, and the
// polarity-aware edge and level detectors.
module eint_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic eint_i,
  input  logic pol_i,
  output logic edge_hit_o,
  output logic level_act_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], eint_i};
      prev_q <= s;
    end
  end

  assign edge_hit_o  = pol_i ? (s & ~prev_q) : (~s & prev_q);
  assign level_act_o = (s == pol_i);

endmodule

// File: rtl/ext_int_ctrl.sv
// External interrupt controller: config registers, pending flags, fixed
// priority arbiter and the irq/ack/done request FSM.
module ext_int_ctrl
  import ext_int_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  ext_int_ctrl_if.slave bus
);

  logic [NUM_SRC-1:0] en_q, mode_q, pol_q;
  logic [NUM_SRC-1:0] edge_pend_q, edge_pend_d;
  logic [NUM_SRC-1:0] hit, lvl, pend, req, cur_oh, clr, set;
  logic [NUM_SRC-1:0] wdata_m;
  logic               wr_en, wr_mode, wr_pol, wr_pend;
  logic               cur_valid, ack_take;
  state_e             state_q;
  logic               irq_q;
  logic [ID_W-1:0]    irq_id_q;
  logic [7:0]         rdata;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    eint_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .rst        (rst),
      .eint_i     (bus.eint_in[g]),
      .pol_i      (pol_q[g]),
      .edge_hit_o (hit[g]),
      .level_act_o(lvl[g])
    );
  end

  assign wdata_m = bus.cfg_wdata[NUM_SRC-1:0];
  assign wr_en   = bus.cfg_we && (bus.cfg_addr == ADDR_ENABLE);
  assign wr_mode = bus.cfg_we && (bus.cfg_addr == ADDR_MODE);
  assign wr_pol  = bus.cfg_we && (bus.cfg_addr == ADDR_POL);
  assign wr_pend = bus.cfg_we && (bus.cfg_addr == ADDR_PEND);

  // Level sources are live; only edge sources hold state.
  assign pend      = (mode_q & edge_pend_q) | (~mode_q & en_q & lvl);
  assign req       = en_q & pend;
  assign cur_oh    = NUM_SRC'(1) << irq_id_q;
  assign cur_valid = |(req & cur_oh);
  assign ack_take  = (state_q == ASSERT) && bus.irq_ack && cur_valid;

  always_comb begin
    clr = '0;
    if (wr_pend)  clr = clr | wdata_m;
    if (wr_en)    clr = clr | ~wdata_m;
    if (ack_take) clr = clr | cur_oh;
    set = en_q & mode_q & hit;
    // A new edge in the same cycle as any clear keeps the flag set.
    edge_pend_d = ((edge_pend_q & ~clr) | set) & mode_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q        <= '0;
      mode_q      <= '0;
      pol_q       <= '0;
      edge_pend_q <= '0;
    end else begin
      if (wr_en)   en_q   <= wdata_m;
      if (wr_mode) mode_q <= wdata_m;
      if (wr_pol)  pol_q  <= wdata_m;
      edge_pend_q <= edge_pend_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          irq_q <= 1'b0;
          if (|req) begin
            irq_id_q <= first_set(8'(req));
            irq_q    <= 1'b1;
            state_q  <= ASSERT;
          end
        end
        ASSERT: begin
          if (!cur_valid) begin
            irq_q   <= 1'b0;
            state_q <= IDLE;
          end else if (bus.irq_ack) begin
            irq_q   <= 1'b0;
            state_q <= SERVICE;
          end
        end
        SERVICE: begin
          irq_q <= 1'b0;
          if (bus.irq_done) state_q <= IDLE;
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.cfg_addr)
      ADDR_ENABLE: rdata = 8'(en_q);
      ADDR_MODE:   rdata = 8'(mode_q);
      ADDR_POL:    rdata = 8'(pol_q);
      ADDR_PEND:   rdata = 8'(pend);
      default:     rdata = '0;
    endcase
  end

  assign bus.cfg_rdata = rdata;
  assign bus.irq       = irq_q;
  assign bus.irq_id    = irq_id_q;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Directed bench for ext_int_ctrl with two sources and two sync stages.
module tb_ext_int_ctrl;
  import ext_int_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ext_int_ctrl_if #(.NUM_SRC(2)) bus ();

  ext_int_ctrl #(.NUM_SRC(2), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
    bus.cfg_addr = a;
    #1;
    chk(tag, 32'(bus.cfg_rdata), 32'(exp));
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  task automatic done();
    bus.irq_done = 1'b1;
    tick();
    bus.irq_done = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.eint_in   = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.irq_ack   = 1'b0;
    bus.irq_done  = 1'b0;
    ticks(2);
    chk("rst_irq", 32'(bus.irq), 0);
    chk("rst_id", 32'(bus.irq_id), 0);
    chk_rd("rst_en", ADDR_ENABLE, 8'h00);
    chk_rd("rst_pend", ADDR_PEND, 8'h00);
    rst = 1'b0;
    tick();

    // Rising edge on source 0: pending after 3 cycles, irq on the 4th.
    wr(ADDR_MODE, 8'h01);
    wr(ADDR_POL, 8'h01);
    wr(ADDR_ENABLE, 8'h01);
    chk_rd("t1_en_rb", ADDR_ENABLE, 8'h01);
    bus.eint_in = 2'b01;
    ticks(2);
    chk_rd("t1_pend_early", ADDR_PEND, 8'h00);
    tick();
    chk_rd("t1_pend", ADDR_PEND, 8'h01);
    chk("t1_irq_pre", 32'(bus.irq), 0);
    tick();
    chk("t1_irq", 32'(bus.irq), 1);
    chk("t1_id", 32'(bus.irq_id), 0);
    ack();
    chk("t1_irq_ack", 32'(bus.irq), 0);
    chk_rd("t1_pend_ack", ADDR_PEND, 8'h00);
    ticks(2);
    done();
    chk("t1_irq_done", 32'(bus.irq), 0);
    tick();
    chk("t1_irq_idle", 32'(bus.irq), 0);
    bus.eint_in = 2'b00;
    ticks(3);

    // Simultaneous edges: source 0 first, source 1 two cycles after done.
    wr(ADDR_MODE, 8'h03);
    wr(ADDR_POL, 8'h03);
    wr(ADDR_ENABLE, 8'h03);
    bus.eint_in = 2'b11;
    ticks(4);
    chk("t2_irq", 32'(bus.irq), 1);
    chk("t2_id0", 32'(bus.irq_id), 0);
    chk_rd("t2_pend", ADDR_PEND, 8'h03);
    ack();
    chk("t2_irq_ack", 32'(bus.irq), 0);
    done();
    chk("t2_gap", 32'(bus.irq), 0);
    tick();
    chk("t2_irq1", 32'(bus.irq), 1);
    chk("t2_id1", 32'(bus.irq_id), 1);
    ack();
    done();
    bus.eint_in = 2'b00;
    ticks(3);
    chk("t2_quiet", 32'(bus.irq), 0);

    // Active-low level on source 1, withdrawn before ack.
    bus.eint_in = 2'b10;
    ticks(3);
    wr(ADDR_ENABLE, 8'h00);
    wr(ADDR_MODE, 8'h00);
    wr(ADDR_POL, 8'h00);
    wr(ADDR_ENABLE, 8'h02);
    chk_rd("t3_pend_idle", ADDR_PEND, 8'h00);
    bus.eint_in = 2'b00;
    ticks(2);
    chk_rd("t3_pend_lvl", ADDR_PEND, 8'h02);
    tick();
    chk("t3_irq", 32'(bus.irq), 1);
    chk("t3_id", 32'(bus.irq_id), 1);
    bus.eint_in = 2'b10;
    ticks(2);
    chk("t3_irq_hold", 32'(bus.irq), 1);
    tick();
    chk("t3_withdraw", 32'(bus.irq), 0);
    chk_rd("t3_pend_gone", ADDR_PEND, 8'h00);
    ticks(2);
    chk("t3_idle", 32'(bus.irq), 0);

    // Edge coincident with W1C, then edge coincident with ack.
    bus.eint_in = 2'b00;
    wr(ADDR_ENABLE, 8'h00);
    wr(ADDR_MODE, 8'h01);
    wr(ADDR_POL, 8'h01);
    wr(ADDR_ENABLE, 8'h01);
    bus.eint_in = 2'b01;
    ticks(2);
    wr(ADDR_PEND, 8'h01);
    chk_rd("t4_w1c_set_wins", ADDR_PEND, 8'h01);
    tick();
    chk("t4_irq", 32'(bus.irq), 1);
    bus.eint_in = 2'b00;
    ticks(3);
    bus.eint_in = 2'b01;
    ticks(2);
    ack();
    chk("t4_irq_svc", 32'(bus.irq), 0);
    chk_rd("t4_ack_set_wins", ADDR_PEND, 8'h01);
    tick();
    done();
    chk("t4_gap", 32'(bus.irq), 0);
    tick();
    chk("t4_rereq", 32'(bus.irq), 1);
    chk("t4_rereq_id", 32'(bus.irq_id), 0);
    ack();
    chk_rd("t4_pend_clr", ADDR_PEND, 8'h00);
    done();
    bus.eint_in = 2'b00;
    ticks(3);

    // Falling-edge mode with a one-cycle glitch.
    wr(ADDR_POL, 8'h00);
    bus.eint_in = 2'b01;
    tick();
    bus.eint_in = 2'b00;
    ticks(2);
    chk_rd("t5_pend_early", ADDR_PEND, 8'h00);
    tick();
    chk_rd("t5_pend", ADDR_PEND, 8'h01);
    tick();
    chk("t5_irq", 32'(bus.irq), 1);
    ack();
    ticks(3);
    chk_rd("t5_single", ADDR_PEND, 8'h00);
    done();
    tick();
    wr(ADDR_ENABLE, 8'h00);
    bus.eint_in = 2'b01;
    tick();
    bus.eint_in = 2'b00;
    ticks(5);
    chk_rd("t5_disabled", ADDR_PEND, 8'h00);
    chk("t5_dis_irq", 32'(bus.irq), 0);

    // Reset while servicing source 1.
    wr(ADDR_MODE, 8'h02);
    wr(ADDR_POL, 8'h02);
    wr(ADDR_ENABLE, 8'h02);
    bus.eint_in = 2'b10;
    ticks(4);
    chk("t6_irq", 32'(bus.irq), 1);
    chk("t6_id", 32'(bus.irq_id), 1);
    ack();
    chk("t6_svc_irq", 32'(bus.irq), 0);
    chk("t6_svc_id", 32'(bus.irq_id), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_irq", 32'(bus.irq), 0);
    chk("t6_rst_id", 32'(bus.irq_id), 0);
    chk_rd("t6_rst_en", ADDR_ENABLE, 8'h00);
    chk_rd("t6_rst_mode", ADDR_MODE, 8'h00);
    chk_rd("t6_rst_pol", ADDR_POL, 8'h00);
    chk_rd("t6_rst_pend", ADDR_PEND, 8'h00);
    bus.eint_in = 2'b00;
    ticks(2);
    rst = 1'b0;
    tick();
    wr(ADDR_MODE, 8'h01);
    wr(ADDR_POL, 8'h01);
    wr(ADDR_ENABLE, 8'h01);
    bus.eint_in = 2'b01;
    ticks(4);
    chk("t6_restart_irq", 32'(bus.irq), 1);
    chk("t6_restart_id", 32'(bus.irq_id), 0);
    ack();
    done();
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
